// File: rtl/mux_pkg.sv
// Shared types and default widths for the arbitrating output mux.
package mux_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_t;

  localparam int DATA_W = 32;

endpackage : mux_pkg

// File: rtl/rr_pick.sv
// Circular priority picker: first requester after ptr, wrapping around to ptr.
module rr_pick #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int idx;

  // Scan ptr+1, ptr+2, ... ptr (mod N) and take the first active request.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      for (int i = 0; i < N; i++) begin
        if (!gnt_any && (i == idx) && req[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end
  end

endmodule : rr_pick

// File: rtl/arb_mux.sv
// N-input registered mux with fixed-select or round-robin arbitration and a
// single tagged output holding register.
module arb_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic [SELW-1:0]  fix_idx;
  logic             fix_any;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] gnt_data;
  mux_mode_t        mode_e;

  assign mode_e = mux_mode_t'(mode);
  assign load   = !out_valid_q || out_ready;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Fixed path: only an in-range sel with a valid channel grants.
  always_comb begin
    fix_idx = '0;
    fix_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((sel == SELW'(i)) && in_valid[i]) begin
        fix_any = 1'b1;
        fix_idx = SELW'(i);
      end
    end
  end

  // Pick the active grant source and steer its data and ready.
  always_comb begin
    gnt_idx  = (mode_e == MUX_RR) ? rr_idx : fix_idx;
    gnt_any  = (mode_e == MUX_RR) ? rr_any : fix_any;
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load && gnt_any;
      end
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load && gnt_any) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_src_d   = gnt_idx;
      if (mode_e == MUX_RR) ptr_d = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset parks ptr at N-1 so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule : arb_mux

// File: tb/tb_arb_mux.sv
// Randomised + directed bench for arb_mux against a transaction-level model.
module tb_arb_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           mode;
  logic [1:0]     sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;

  // Second instance with a non-power-of-two channel count.
  logic [2:0]     in_valid3;
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_ready3;
  logic           out_valid3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_src3;
  logic [1:0]     sel3;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_src;
  int          m_last_rr;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .N(N)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(W), .N(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .mode      (1'b0),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_src   (out_src3),
    .out_ready (1'b1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Which channel should win right now, straight from the selection rules.
  task automatic model_grant(output int g, output bit ga);
    g  = 0;
    ga = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin g = int'(sel); ga = 1; end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last_rr + k) % N;
        if (!ga && in_valid[c]) begin g = c; ga = 1; end
      end
    end
  endtask

  // One clock: inputs already driven; check ready, clock, check registered outputs.
  task automatic cycle();
    int g; bit ga; bit ld;
    logic [N-1:0] exp_rdy;
    #1;
    model_grant(g, ga);
    ld = !m_valid || out_ready;
    exp_rdy = (ga && ld) ? N'(1 << g) : '0;
    if (!reset) chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_data = '0; m_src = 0; m_last_rr = N - 1;
    end else if (ga && ld) begin
      m_valid = 1; m_data = in_data[g*W +: W]; m_src = g;
      if (mode) m_last_rr = g;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_src",   64'(out_src),   64'(m_src));
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom();
  endtask

  initial begin
    logic [W-1:0] held;
    reset = 1; mode = 0; sel = 0; in_valid = '0; in_data = '0; out_ready = 1;
    in_valid3 = '0; in_data3 = '0; sel3 = 2'd3;
    m_valid = 0; m_data = '0; m_src = 0; m_last_rr = N - 1;
    cycle();
    cycle();
    reset = 0;

    // Fixed select of channel 2
    mode = 0; sel = 2; in_valid = 4'b1111; rand_data();
    in_data[2*W +: W] = 32'hDEADBEEF;
    cycle();
    chk("fixed_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);

    // Fixed select of an idle channel: no grant, held word drains
    sel = 1; in_valid = 4'b1101;
    cycle();
    cycle();

    // Round-robin fairness from reset pointer
    mode = 1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cycle();
      chk("rr_seq", 64'(out_src), 64'(i % N));
    end

    // Sparse requests then a stall
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin rand_data(); cycle(); end
    out_ready = 0;
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      rand_data(); cycle();
      chk("stall_hold", 64'(out_data), 64'(held));
    end
    out_ready = 1;
    cycle();

    // Reset during a stall, then the next round-robin grant must be 0
    out_ready = 0; in_valid = 4'b1111; cycle();
    reset = 1; cycle();
    reset = 0; out_ready = 1; in_valid = 4'b1111; rand_data();
    cycle();
    chk("rr_after_reset", 64'(out_src), 64'd0);

    // Back-to-back drain and reload
    mode = 0; sel = 0; in_valid = 4'b0001; in_data[W-1:0] = 32'h1;
    cycle();
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_data",  64'(out_data),  64'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom());
      sel       = 2'($urandom());
      in_valid  = 4'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
    end
    reset = 0;

    // N=3 with sel=3 must never grant
    in_valid3 = 3'b111;
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = $urandom();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("n3_ready", 64'(in_ready3), 64'd0);
      @(posedge clk); #1;
      chk("n3_valid", 64'(out_valid3), 64'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_arb_mux

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes: fixed (external `sel`, as a plain mux) and round-robin arbitration across valid inputs.
- Single output holding register, so results are registered, stall-safe and tagged with their source channel.
- Sits between multiple datapath/bus producers (e.g. instruction fetch, load/store, debug) and one shared consumer.

Parameters:
- WIDTH, 32, data width per channel in bits.
- N, 4, number of input channels (N >= 2, need not be a power of two).
- SELW, $clog2(N), select/source index width (localparam, not overridable).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- mode, input, 1, 0 = fixed select, 1 = round-robin.
- sel, input, SELW, channel index used in fixed mode.
- in_valid, input, N, per-channel data valid.
- in_data, input, N*WIDTH, flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready, output, N, per-channel accept (one-hot or zero).
- out_valid, output, 1, output register holds a word.
- out_data, output, WIDTH, registered data.
- out_src, output, SELW, index of the channel that supplied out_data.
- out_ready, input, 1, consumer accepts the output word.

Behaviour:
- Reset (synchronous, checked each edge, overrides all else):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer ptr=N-1, so the first search starts at channel 0.
  - Any held word is discarded.
- load = !out_valid || out_ready. The register is empty or draining this cycle; full throughput of 1 word/cycle.
- Grant, computed combinationally each cycle:
  - Fixed mode: grant = sel when sel < N and in_valid[sel]=1; otherwise no grant. A sel >= N never grants.
  - Round-robin mode: first i with in_valid[i]=1, scanning (ptr+1) mod N, (ptr+2) mod N, …, ptr. No valid input means no grant.
- in_ready[g] = load && grant==g; all other in_ready bits are 0. in_ready never depends on in_valid of a non-granted channel.
- Transfer on edge when a grant exists and load=1:
  - out_data <= in_data[grant], out_src <= grant, out_valid <= 1.
  - In round-robin mode only, ptr <= grant.
- If out_valid && out_ready and no grant: out_valid <= 0. out_data and out_src hold their last values.
- Stall: while out_valid && !out_ready, out_data and out_src are held stable and in_ready is all-zero.
- Latency: input handshake at edge k, data visible at out_data after edge k, i.e. 1 cycle.
- Mode or sel changes take effect on the next grant evaluation. They never alter a word already held.
- ptr is not updated in fixed mode. Switching back to round-robin resumes from the last round-robin grant.
- Simultaneous output drain and new load in the same edge: the new word replaces the old one with no bubble.
- Fairness: in round-robin mode, with every channel continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,…
- No combinational path from out_ready to out_valid/out_data. There is a combinational path out_ready -> in_ready, which is permitted.

Decomposition:
- Shared package `mux_pkg`:
  - typedef enum logic {MUX_FIXED=1'b0, MUX_RR=1'b1} mux_mode_t.
  - Default-width constants (DATA_W=32).
- Sub-module `rr_pick`:
  - Purely combinational circular priority picker.
  - Parameter N; inputs req[N-1:0] and ptr; outputs gnt_idx and gnt_any.
  - Instantiated once.
- arb_mux owns the output register, ptr register, load/ready logic and the fixed-mode path.

Test Plan:
- Reset mid-stall: hold out_valid=1, out_ready=0, assert reset one cycle -> next cycle out_valid=0, out_data=0, out_src=0, and the next round-robin grant goes to channel 0.
- Fixed mode, N=4, sel=2, in_valid=4'b1111, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; after 1 edge out_valid=1, out_data=32'hDEADBEEF, out_src=2.
- Fixed mode, sel=1, in_valid=4'b1101 -> in_ready=0 and out_valid deasserts after the held word drains; N=3 with sel=3 -> never grants.
- Round-robin, all valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 and one word per cycle.
- Round-robin, in_valid=4'b1010, ptr after channel 1 -> next grant 3, then 1; stall out_ready=0 for 3 cycles -> out_data stable, in_ready=0, no grant lost.
- Back-to-back drain+load: out_valid=1, out_ready=1, channel 0 valid with 32'h00000001 -> the same edge replaces the word, out_valid stays 1, out_data=32'h00000001.
